// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-op expander for the ID stage: one single-register micro-op per set list bit.
// Optional LMSM_PERF_CNT_EN adds a saturating freeze_cycles counter output.
module lm_sm_sequencer #(
  parameter int         WORD_LEN = 16,
  parameter logic [3:0] OPC_LM   = 4'b0110,
  parameter logic [3:0] OPC_SM   = 4'b0111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [WORD_LEN-1:0] instr,
  input  logic                flush_in,
  input  logic                stall_in,
  output logic                freeze,
  output logic                busy,
  output logic                uop_valid,
  output logic                uop_is_load,
  output logic [2:0]          uop_reg,
  output logic [2:0]          uop_base,
  output logic [2:0]          uop_offset,
  output logic                uop_first,
  output logic                uop_last,
`ifdef LMSM_PERF_CNT_EN
  output logic [15:0]         freeze_cycles,
`endif
  output logic                done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] list_q, list_d;
  logic [2:0] offset_q, offset_d;
  logic [2:0] base_q, base_d;
  logic       load_q, load_d;
  logic       done_q, done_d;

  logic [3:0] opcode;
  logic       is_lmsm;
  logic       in_seq;
  logic [2:0] low_idx;
  logic       one_left;
  logic       unused_instr_bit;

  assign opcode           = instr[15:12];
  assign is_lmsm          = (opcode == OPC_LM) || (opcode == OPC_SM);
  assign in_seq           = (state_q == ST_SEQ);
  assign unused_instr_bit = instr[8];
  // Remaining list is never zero in SEQ, so "no other bit set" means exactly one left.
  assign one_left         = ((list_q & (list_q - 8'd1)) == 8'd0);

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (list_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    list_d   = list_q;
    offset_d = offset_q;
    base_d   = base_q;
    load_d   = load_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && is_lmsm && !flush_in) begin
          if (instr[7:0] != 8'd0) begin
            list_d   = instr[7:0];
            base_d   = instr[11:9];
            load_d   = (opcode == OPC_LM);
            offset_d = 3'd0;
            state_d  = ST_SEQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (flush_in) begin
          state_d  = ST_IDLE;
          list_d   = 8'd0;
          offset_d = 3'd0;
        end else if (!stall_in) begin
          list_d = list_q & (list_q - 8'd1);
          if (one_left) begin
            state_d  = ST_IDLE;
            offset_d = 3'd0;
            done_d   = 1'b1;
          end else begin
            offset_d = offset_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      list_q   <= 8'd0;
      offset_q <= 3'd0;
      base_q   <= 3'd0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      list_q   <= list_d;
      offset_q <= offset_d;
      base_q   <= base_d;
      load_q   <= load_d;
      done_q   <= done_d;
    end
  end

  assign freeze      = in_seq;
  assign busy        = in_seq;
  assign uop_valid   = in_seq && !flush_in;
  assign uop_is_load = in_seq && load_q;
  assign uop_reg     = in_seq ? low_idx  : 3'd0;
  assign uop_base    = in_seq ? base_q   : 3'd0;
  assign uop_offset  = in_seq ? offset_q : 3'd0;
  assign uop_first   = in_seq && (offset_q == 3'd0);
  assign uop_last    = in_seq && one_left;
  assign done        = done_q;

`ifdef LMSM_PERF_CNT_EN
  logic [15:0] freeze_cycles_q, freeze_cycles_d;

  always_comb begin
    freeze_cycles_d = freeze_cycles_q;
    if (in_seq && (freeze_cycles_q != 16'hFFFF)) freeze_cycles_d = freeze_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) freeze_cycles_q <= 16'd0;
    else     freeze_cycles_q <= freeze_cycles_d;
  end

  assign freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        flush_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        freeze, busy, uop_valid, uop_is_load, uop_first, uop_last, done;
  logic [2:0]  uop_reg, uop_base, uop_offset;
`ifdef LMSM_PERF_CNT_EN
  logic [15:0] freeze_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: pending registers kept as a queue of indices.
  bit   m_busy = 0;
  int   m_q[$];
  int   m_cnt = 0;
  logic [2:0] m_base = 3'd0;
  bit   m_load = 0;
  bit   m_done = 0;
  int   m_fc = 0;

  lm_sm_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .flush_in(flush_in), .stall_in(stall_in), .freeze(freeze), .busy(busy),
    .uop_valid(uop_valid), .uop_is_load(uop_is_load), .uop_reg(uop_reg),
    .uop_base(uop_base), .uop_offset(uop_offset), .uop_first(uop_first),
    .uop_last(uop_last),
`ifdef LMSM_PERF_CNT_EN
    .freeze_cycles(freeze_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {freeze, busy, uop_valid, uop_is_load, uop_reg, uop_base, uop_offset,
            uop_first, uop_last, done};
  endfunction

  function automatic logic [15:0] model_out();
    logic [15:0] e;
    if (m_busy)
      e = {1'b1, 1'b1, !flush_in, m_load, 3'(m_q[0]), m_base, 3'(m_cnt),
           (m_cnt == 0), (m_q.size() == 1), m_done};
    else
      e = {15'd0, m_done};
    return e;
  endfunction

  task automatic model_step();
    bit nd = 0;
    if (rst) begin
      m_busy = 0; m_q.delete(); m_cnt = 0; m_base = 3'd0; m_load = 0; m_done = 0; m_fc = 0;
    end else begin
      if (m_busy && m_fc < 65535) m_fc++;
      if (m_busy) begin
        if (flush_in) begin
          m_busy = 0; m_q.delete();
        end else if (!stall_in) begin
          void'(m_q.pop_front());
          m_cnt++;
          if (m_q.size() == 0) begin m_busy = 0; nd = 1; end
        end
      end else if (instr_valid && (instr[15:12] == 4'h6 || instr[15:12] == 4'h7) && !flush_in) begin
        for (int i = 0; i < 8; i++) if (instr[i]) m_q.push_back(i);
        if (m_q.size() == 0) nd = 1;
        else begin
          m_busy = 1; m_cnt = 0; m_base = instr[11:9]; m_load = (instr[15:12] == 4'h6);
        end
      end
      m_done = nd;
    end
  endtask

  task automatic set_in(input bit v, input logic [15:0] i, input bit f, input bit s, input bit r);
    instr_valid = v; instr = i; flush_in = f; stall_in = s; rst = r;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 16'h64A5, 0, 0, 1);
    advance();
    advance();
    checks++;
    if (obs() !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs(), 16'h0);
    end
    set_in(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_lm_basic();
    int exp_reg[4] = '{0, 2, 5, 7};
    int fz = 0;
    set_in(1, 16'h64A5, 0, 0, 0);
    checks++;
    if (freeze !== 1'b0) begin errors++; $display("FAIL lm_accept_nofreeze: got %b expected 0", freeze); end
    advance();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 16'h7203, 0, 0, 0);
      fz += freeze;
      checks++;
      if ({uop_valid, uop_reg, uop_offset, uop_first, uop_last, uop_is_load, uop_base} !==
          {1'b1, 3'(exp_reg[k]), 3'(k), (k == 0), (k == 3), 1'b1, 3'd2}) begin
        errors++;
        $display("FAIL lm_uop%0d: got reg=%0d off=%0d first=%b last=%b ld=%b base=%0d expected reg=%0d off=%0d",
                 k, uop_reg, uop_offset, uop_first, uop_last, uop_is_load, uop_base, exp_reg[k], k);
      end
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL lm_model%0d: got %h expected %h", k, obs(), model_out());
      end
      advance();
    end
    set_in(0, 16'h0, 0, 0, 0);
    checks++;
    if ({done, freeze} !== 2'b10) begin errors++; $display("FAIL lm_done: got done=%b freeze=%b expected 1 0", done, freeze); end
    advance();
    checks++;
    if ({done, fz} !== {1'b0, 32'd4}) begin errors++; $display("FAIL lm_end: got done=%b freezes=%0d expected 0 4", done, fz); end
  endtask

  task automatic test_sm_single();
    set_in(1, 16'h7201, 0, 0, 0);
    advance();
    set_in(0, 16'h0, 0, 0, 0);
    checks++;
    if ({uop_valid, uop_reg, uop_first, uop_last, uop_is_load, freeze, uop_base} !==
        {1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1}) begin
      errors++; $display("FAIL sm_single: got %h expected fields v=1 reg=0 f=1 l=1 ld=0 fz=1 base=1", obs());
    end
    advance();
    checks++;
    if ({freeze, done} !== 2'b01) begin errors++; $display("FAIL sm_done: got fz=%b done=%b expected 0 1", freeze, done); end
    advance();
  endtask

  task automatic test_zero_list();
    int fz = 0, uv = 0, dn = 0;
    set_in(1, 16'h6400, 0, 0, 0);
    fz += freeze; uv += uop_valid; dn += done;
    advance();
    set_in(0, 16'h0, 0, 0, 0);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    for (int k = 0; k < 4; k++) begin
      fz += freeze; uv += uop_valid; dn += done;
      advance();
    end
    checks++;
    if (fz != 0 || uv != 0 || dn != 1) begin
      errors++; $display("FAIL zero_totals: got fz=%0d uv=%0d done=%0d expected 0 0 1", fz, uv, dn);
    end
  endtask

  task automatic test_stall();
    int er[6] = '{0, 2, 2, 2, 5, 7};
    int eo[6] = '{0, 1, 1, 1, 2, 3};
    bit st[6] = '{0, 1, 1, 0, 0, 0};
    int fz = 0, dn = 0;
    set_in(1, 16'h64A5, 0, 0, 0);
    advance();
    for (int k = 0; k < 6; k++) begin
      set_in(0, 16'h0, 0, st[k], 0);
      fz += freeze;
      checks++;
      if ({uop_valid, uop_reg, uop_offset} !== {1'b1, 3'(er[k]), 3'(eo[k])}) begin
        errors++; $display("FAIL stall_c%0d: got v=%b reg=%0d off=%0d expected 1 %0d %0d",
                           k, uop_valid, uop_reg, uop_offset, er[k], eo[k]);
      end
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      set_in(0, 16'h0, 0, 0, 0);
      fz += freeze; dn += done;
      advance();
    end
    checks++;
    if (fz != 6 || dn != 1) begin errors++; $display("FAIL stall_totals: got fz=%0d done=%0d expected 6 1", fz, dn); end
  endtask

  task automatic test_flush();
    int dn = 0;
    set_in(1, 16'h64A5, 0, 0, 0);
    advance();
    for (int k = 0; k < 2; k++) begin set_in(0, 16'h0, 0, 0, 0); advance(); end
    set_in(0, 16'h0, 1, 1, 0);
    checks++;
    if ({uop_valid, freeze} !== 2'b01) begin errors++; $display("FAIL flush_cycle: got v=%b fz=%b expected 0 1", uop_valid, freeze); end
    advance();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 16'h0, 0, 0, 0);
      dn += done;
      checks++;
      if ({freeze, busy, uop_valid} !== 3'b000) begin
        errors++; $display("FAIL flush_idle%0d: got fz=%b busy=%b v=%b expected 000", k, freeze, busy, uop_valid);
      end
      advance();
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL flush_nodone: got %0d expected 0", dn); end
  endtask

  task automatic test_rst_mid();
    set_in(1, 16'h64A5, 0, 0, 0);
    advance();
    set_in(0, 16'h0, 0, 0, 0);
    advance();
    set_in(0, 16'h0, 0, 0, 1);
    advance();
    set_in(0, 16'h0, 0, 0, 0);
    checks++;
    if (obs() !== 16'h0) begin errors++; $display("FAIL rst_mid: got %h expected %h", obs(), 16'h0); end
    test_sm_single();
  endtask

  task automatic test_back_to_back();
    set_in(1, 16'h7201, 0, 0, 0);
    advance();
    set_in(1, 16'h6403, 0, 0, 0);
    advance();
    checks++;
    if ({done, freeze} !== 2'b10) begin errors++; $display("FAIL b2b_ret: got done=%b fz=%b expected 1 0", done, freeze); end
    advance();
    set_in(0, 16'h0, 0, 0, 0);
    checks++;
    if ({freeze, uop_reg, uop_is_load, uop_base, uop_first} !== {1'b1, 3'd0, 1'b1, 3'd2, 1'b1}) begin
      errors++; $display("FAIL b2b_uop0: got %h expected fz=1 reg=0 ld=1 base=2 first=1", obs());
    end
    advance();
    checks++;
    if ({uop_reg, uop_last, uop_offset} !== {3'd1, 1'b1, 3'd1}) begin
      errors++; $display("FAIL b2b_uop1: got reg=%0d last=%b off=%0d expected 1 1 1", uop_reg, uop_last, uop_offset);
    end
    advance();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", done); end
    advance();
  endtask

  task automatic test_random();
    logic [15:0] ri;
    logic [11:0] lo;
    bit v, f, s, r;
    for (int c = 0; c < 600; c++) begin
      lo = 12'($urandom());
      if ($urandom_range(0, 4) == 0) lo[7:0] = 8'h00;
      case ($urandom_range(0, 3))
        0: ri = {4'h6, lo};
        1: ri = {4'h7, lo};
        default: ri = 16'($urandom());
      endcase
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 49) == 0);
      set_in(v, ri, f, s, r);
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL rand_c%0d: got %h expected %h", c, obs(), model_out());
      end
`ifdef LMSM_PERF_CNT_EN
      checks++;
      if (freeze_cycles !== 16'(m_fc)) begin
        errors++; $display("FAIL rand_fc%0d: got %0d expected %0d", c, freeze_cycles, m_fc);
      end
`endif
      advance();
    end
    set_in(0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_single();
    test_zero_list();
    test_stall();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Expands multi-register load/store instructions (LM/SM) in the ID stage into one single-register micro-op per set bit of the 8-bit register list.
- While expanding, it freezes the IF/ID pipeline register and the PC, and its micro-ops override the normal ID decode output.
- It sits beside the decoder and drives the freeze input of the IF/ID register.
- It handles flush from branch resolution and stall from downstream stages.

Parameters:
- WORD_LEN, 16, instruction/data word width.
- OPC_LM, 4'b0110, opcode for load-multiple.
- OPC_SM, 4'b0111, opcode for store-multiple.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- instr_valid  input  1  ID-stage instruction valid.
- instr  input  WORD_LEN  ID-stage instruction. Fields: [15:12] opcode, [11:9] RA base register, [7:0] register list.
- flush_in  input  1  squash ID stage (older branch/jump resolved).
- stall_in  input  1  downstream cannot accept a micro-op this cycle.
- freeze  output  1  hold IF/ID and PC.
- busy  output  1  sequence in progress.
- uop_valid  output  1  micro-op present.
- uop_is_load  output  1  1 = LM, 0 = SM.
- uop_reg  output  3  register loaded/stored by this micro-op.
- uop_base  output  3  latched RA.
- uop_offset  output  3  word offset from base (0..7).
- uop_first  output  1  first micro-op of the sequence; downstream captures the RA value here.
- uop_last  output  1  final micro-op.
- done  output  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (synchronous, rst high at posedge): state IDLE; remaining list, offset, base, type cleared. All outputs 0. rst has priority over all other inputs, including mid-sequence.
- States are IDLE and SEQ.
- IDLE, accept condition: instr_valid and opcode is OPC_LM or OPC_SM and not flush_in.
  - Non-zero list: latch list, RA, and type; offset <= 0; go to SEQ next edge.
  - Zero list: stay in IDLE; done pulses the following cycle; no freeze, no micro-ops.
- SEQ outputs:
  - freeze = busy = 1 in every SEQ cycle (registered from state).
  - uop_valid = 1 unless flush_in.
  - uop_reg = index of the lowest set bit of the remaining list (priority encode, bit 0 first).
  - uop_offset = count of micro-ops already issued.
  - uop_first = (offset == 0).
  - uop_last = exactly one bit remaining.
- SEQ issue edge (stall_in = 0): clear the issued bit; offset += 1.
  - If uop_last: go to IDLE and pulse done next cycle.
  - Micro-op count equals popcount(list); expansion adds popcount cycles of freeze.
- SEQ with stall_in = 1: all state and outputs held unchanged; the same micro-op is re-presented.
- SEQ with flush_in = 1: uop_valid forced 0 that cycle; go to IDLE next edge; remaining list cleared; no done pulse. flush_in overrides stall_in.
- While in SEQ, instr/instr_valid are ignored; they reflect the frozen next instruction.
- After return to IDLE, freeze is low. IF/ID resumes and the frozen instruction is decoded normally; back-to-back LM/SM is accepted on that cycle.
- Offset is 3 bits and never wraps (max 7 with 8 list bits).

Optional Feature:
LMSM_PERF_CNT_EN
- Defined: adds output port freeze_cycles (16 bits), a saturating count of cycles with freeze = 1. Cleared by rst; holds at 16'hFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then instr = 0x64A5 (LM, RA = R2, list 0xA5), valid for 1 cycle, no stall -> 4 micro-ops over 4 consecutive cycles:
  - uop_reg 0, 2, 5, 7 with offsets 0, 1, 2, 3 and uop_is_load = 1;
  - first on uop 0, last on uop 3;
  - freeze high exactly those 4 cycles; done pulses once in the next cycle.
- instr = 0x7201 (SM, RA = R1, list 0x01) -> a single micro-op with uop_reg 0, first = last = 1, uop_is_load = 0; freeze for 1 cycle.
- instr = 0x6400 (zero list) -> no uop_valid, freeze never high, done pulses once.
- 0x64A5 with stall_in high for 2 cycles during the 2nd micro-op -> uop_reg 2 / offset 1 held for 3 cycles; total freeze 6 cycles; sequence otherwise unchanged.
- 0x64A5 with flush_in after 2 micro-ops issued -> uop_valid 0 that cycle, IDLE next cycle, no done pulse, freeze low.
- rst asserted mid-sequence (after 1 micro-op) -> all outputs 0 next cycle; a subsequent 0x7201 executes normally.
